onehot_collector: RTL and testbench
===================================

ONEHOT_COLLECTOR -- requirements
Module: onehot_collector

Interface
REQ-001 Parameter WIDTH, default 16: number of slots, equal to the width of the one-hot select vector.
REQ-002 Parameter DATA_W, default 16: data word width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  low = synchronous clear to FILL, empty buffer.
REQ-006 sel  input  WIDTH  one-hot slot strobe, all-zero = no write.
REQ-007 wr_data  input  DATA_W  word written to the selected slot.
REQ-008 out_data  output  DATA_W  drained word, buf[out_idx].
REQ-009 out_idx  output  clog2(WIDTH)  slot index of out_data.
REQ-010 out_valid  output  1  drain beat valid.
REQ-011 out_ready  input  1  consumer accepts beat.
REQ-012 full  output  1  all WIDTH slots written, high throughout DRAIN.
REQ-013 done  output  1  one-cycle pulse on acceptance of the last drain beat.
REQ-014 err  output  1  sticky protocol-error flag.

Function
REQ-015 FSM states: FILL and DRAIN only; reset and enable low both force FILL.
REQ-016 FILL: sel with exactly one bit k set -> buf[k] <= wr_data and mask[k] <= 1 on the same edge.
REQ-017 Rewriting an already-filled slot overwrites buf[k] without error.
REQ-018 FILL, sel == 0: no state change.
REQ-019 A write that completes the mask (mask == all ones after the edge) moves the FSM to DRAIN on that same edge; out_valid and full are high the following cycle.
REQ-020 DRAIN: out_valid = 1, out_idx starts at 0, out_data = buf[out_idx], combinational from registers.
REQ-021 out_valid high with out_ready low: out_idx and out_data hold stable.
REQ-022 out_valid and out_ready both high: out_idx increments by 1 on the edge.
REQ-023 Beat at out_idx == WIDTH-1 accepted: done = 1 for one cycle, mask cleared, out_idx = 0, FSM returns to FILL; out_valid and full drop on the same edge.
REQ-024 A sel write in the cycle the last beat is accepted is dropped, because the write belongs to DRAIN.
REQ-025 enable low in any state: mask, out_idx and err clear, FSM goes to FILL, done stays 0, buffer contents are not cleared.
REQ-026 Drain order is always ascending index, independent of fill order.

Reset
REQ-027 reset_n low asynchronously clears mask, out_idx, err and FSM (FILL).
REQ-028 During reset: out_valid = 0, full = 0, done = 0, err = 0, out_idx = 0.
REQ-029 buf contents are undefined after reset; out_data is don't-care while out_valid = 0.
REQ-030 Reset asserted mid-DRAIN aborts the drain with no done pulse.

Configuration
REQ-031 Macro ONEHOT_COLLECTOR_CHECK_EN defined: sel with more than one bit set is ignored (no write, no mask change) and sets err.
REQ-032 Macro ONEHOT_COLLECTOR_CHECK_EN defined: any nonzero sel during DRAIN is dropped and sets err.
REQ-033 Macro ONEHOT_COLLECTOR_CHECK_EN undefined: err is tied to 0.
REQ-034 Macro ONEHOT_COLLECTOR_CHECK_EN undefined: multi-hot sel writes only the lowest set bit's slot.
REQ-035 Macro ONEHOT_COLLECTOR_CHECK_EN undefined: writes during DRAIN are silently dropped.

Verification (WIDTH=4, DATA_W=8)
REQ-036 Bench covers: walking-one sel 0001,0010,0100,1000 with data 0x11,0x22,0x33,0x44, out_ready=1 -> out_valid 1 cycle after the last write; beats 0x11,0x22,0x33,0x44 with idx 0..3 on consecutive cycles; done pulses once.
REQ-037 Bench covers: fill order 1000,0001,0100,0010 with data 0xA0..0xA3 -> drain ascending 0xA1,0xA3,0xA2,0xA0.
REQ-038 Bench covers: out_ready low for 3 cycles at idx 2 -> out_idx=2 and out_data held; drain resumes with no beat lost or duplicated.
REQ-039 Bench covers: sel=0011 in FILL with CHECK_EN -> mask unchanged, err=1 sticky until enable low; without CHECK_EN -> slot 0 written, err=0.
REQ-040 Bench covers: reset_n low mid-drain at idx 1 -> out_valid=0, full=0, done=0 immediately; next fill starts from an empty mask.
REQ-041 Bench covers: enable low for 1 cycle after 3 writes -> a 4th write does not set full; 4 fresh writes are required before drain.

Source files
------------

// File: rtl/onehot_collector.sv
// Collects WIDTH words written through a one-hot slot strobe, then drains them in ascending slot order.
// Define ONEHOT_COLLECTOR_CHECK_EN to reject multi-hot / drain-time writes and flag them on err.
module onehot_collector #(
  parameter int WIDTH  = 16,
  parameter int DATA_W = 16,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [WIDTH-1:0]  sel,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              full,
  output logic              done,
  output logic              err
);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t            state;
  logic [WIDTH-1:0]  mask;
  logic [DATA_W-1:0] slot_buf [WIDTH];
  logic [IDX_W-1:0]  low_idx;
  logic [WIDTH-1:0]  sel_vec;
  logic [WIDTH-1:0]  mask_next;
  logic              wr_ok;
  logic              wr_en;
  logic              last_beat;

  // Scanning from the top down leaves the lowest set bit as the winner.
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (sel[i]) low_idx = IDX_W'(i);
    end
  end

`ifdef ONEHOT_COLLECTOR_CHECK_EN
  logic multi_hot;
  logic proto_err;
  assign multi_hot = (sel & (sel - WIDTH'(1))) != '0;
  assign wr_ok     = (|sel) && !multi_hot;
  assign proto_err = (|sel) && ((state == DRAIN) || multi_hot);
`else
  assign wr_ok = |sel;
`endif

  assign sel_vec   = WIDTH'(1) << low_idx;
  assign mask_next = mask | sel_vec;
  assign wr_en     = enable && (state == FILL) && wr_ok;
  assign last_beat = out_idx == IDX_W'(WIDTH - 1);
  assign out_data  = slot_buf[out_idx];

  // Buffer storage has no reset; contents only matter once every slot is rewritten.
  always_ff @(posedge clk) begin
    if (wr_en) slot_buf[low_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FILL;
      mask      <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      full      <= 1'b0;
      done      <= 1'b0;
    end else if (!enable) begin
      state     <= FILL;
      mask      <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      full      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        FILL: begin
          if (wr_en) begin
            mask <= mask_next;
            if (mask_next == '1) begin
              state     <= DRAIN;
              out_idx   <= '0;
              out_valid <= 1'b1;
              full      <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (last_beat) begin
              state     <= FILL;
              mask      <= '0;
              out_idx   <= '0;
              out_valid <= 1'b0;
              full      <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_idx <= out_idx + IDX_W'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef ONEHOT_COLLECTOR_CHECK_EN
  // Sticky until reset or enable low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      err <= 1'b0;
    else if (!enable)  err <= 1'b0;
    else if (proto_err) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_collector.sv
// Self-checking bench for onehot_collector (WIDTH=4, DATA_W=8): directed scenarios plus random traffic
// compared every cycle against a slot-level reference model.
module tb_onehot_collector;

  localparam int WIDTH  = 4;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [WIDTH-1:0]  sel;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_idx;
  logic              out_valid;
  logic              out_ready;
  logic              full;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;

  // Reference model: which slots hold data, what they hold, and drain progress.
  bit          m_drain;
  bit          m_filled [WIDTH];
  logic [7:0]  m_buf [WIDTH];
  int          m_idx;
  bit          m_done;
  bit          m_err;

  bit check_en;
  logic [7:0] fill_order_exp [4];

  onehot_collector #(.WIDTH(WIDTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sel(sel), .wr_data(wr_data),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .full(full), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void modelClear();
    m_drain = 1'b0;
    m_idx   = 0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    for (int i = 0; i < WIDTH; i++) m_filled[i] = 1'b0;
  endfunction

  function automatic void modelStep(bit en, logic [3:0] s, logic [7:0] d, bit rdy);
    int k;
    int n;
    bit all_filled;
    m_done = 1'b0;
    if (!en) begin
      modelClear();
      return;
    end
    n = $countones(s);
    if (!m_drain) begin
      if (n > 0) begin
        if (check_en && n > 1) begin
          m_err = 1'b1;
          return;
        end
        k = 0;
        while (!s[k]) k++;
        m_buf[k]    = d;
        m_filled[k] = 1'b1;
        all_filled = 1'b1;
        for (int i = 0; i < WIDTH; i++) if (!m_filled[i]) all_filled = 1'b0;
        if (all_filled) begin
          m_drain = 1'b1;
          m_idx   = 0;
        end
      end
    end else begin
      if (check_en && n > 0) m_err = 1'b1;
      if (rdy) begin
        if (m_idx == WIDTH - 1) begin
          m_done  = 1'b1;
          m_drain = 1'b0;
          m_idx   = 0;
          for (int i = 0; i < WIDTH; i++) m_filled[i] = 1'b0;
        end else begin
          m_idx++;
        end
      end
    end
  endfunction

  task automatic checkOutput();
    cmp("out_valid", out_valid, m_drain);
    cmp("full", full, m_drain);
    cmp("done", done, m_done);
    cmp("err", err, m_err);
    cmp("out_idx", out_idx, m_idx);
    if (m_drain) cmp("out_data", out_data, m_buf[m_idx]);
  endtask

  task automatic applyStimulus(input bit en, input logic [3:0] s, input logic [7:0] d, input bit rdy);
    enable    = en;
    sel       = s;
    wr_data   = d;
    out_ready = rdy;
    @(posedge clk);
    modelStep(en, s, d, rdy);
    #1;
    checkOutput();
  endtask

  task automatic drainAll();
    for (int i = 0; i < WIDTH; i++) applyStimulus(1'b1, 4'b0000, 8'h00, 1'b1);
  endtask

  task automatic fillAll(input logic [7:0] base);
    for (int i = 0; i < WIDTH; i++) applyStimulus(1'b1, 4'(1 << i), 8'(base + i), 1'b1);
  endtask

  initial begin
`ifdef ONEHOT_COLLECTOR_CHECK_EN
    check_en = 1'b1;
`else
    check_en = 1'b0;
`endif
    reset_n   = 1'b0;
    enable    = 1'b0;
    sel       = '0;
    wr_data   = '0;
    out_ready = 1'b0;
    modelClear();
    #2;
    checkOutput();
    #10;
    reset_n = 1'b1;

    // Walking-one fill, drain on consecutive cycles.
    for (int i = 0; i < WIDTH; i++) applyStimulus(1'b1, 4'(1 << i), 8'(17 * (i + 1)), 1'b1);
    cmp("walk_valid", out_valid, 1);
    for (int i = 0; i < WIDTH; i++) begin
      cmp("walk_data", out_data, 8'(17 * (i + 1)));
      cmp("walk_idx", out_idx, i);
      applyStimulus(1'b1, 4'b0000, 8'h00, 1'b1);
    end
    cmp("walk_done", done, 1);
    applyStimulus(1'b1, 4'b0000, 8'h00, 1'b1);
    cmp("walk_done_once", done, 0);

    // Out-of-order fill drains in ascending index order.
    applyStimulus(1'b1, 4'b1000, 8'hA0, 1'b0);
    applyStimulus(1'b1, 4'b0001, 8'hA1, 1'b0);
    applyStimulus(1'b1, 4'b0100, 8'hA2, 1'b0);
    applyStimulus(1'b1, 4'b0010, 8'hA3, 1'b0);
    fill_order_exp = '{8'hA1, 8'hA3, 8'hA2, 8'hA0};
    for (int i = 0; i < WIDTH; i++) begin
      cmp("order_data", out_data, fill_order_exp[i]);
      applyStimulus(1'b1, 4'b0000, 8'h00, 1'b1);
    end

    // Back-pressure for three cycles at index 2.
    fillAll(8'h50);
    applyStimulus(1'b1, 4'b0000, 8'h00, 1'b1);
    applyStimulus(1'b1, 4'b0000, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'b0000, 8'h00, 1'b0);
      cmp("stall_idx", out_idx, 2);
      cmp("stall_data", out_data, 8'h52);
    end
    applyStimulus(1'b1, 4'b0000, 8'h00, 1'b1);
    cmp("resume_data", out_data, 8'h53);
    applyStimulus(1'b1, 4'b0000, 8'h00, 1'b1);
    cmp("resume_done", done, 1);

    // Multi-hot select in FILL.
    applyStimulus(1'b1, 4'b0011, 8'h77, 1'b0);
    cmp("mh_err", err, check_en);
    applyStimulus(1'b1, 4'b0010, 8'h81, 1'b0);
    applyStimulus(1'b1, 4'b0100, 8'h82, 1'b0);
    applyStimulus(1'b1, 4'b1000, 8'h83, 1'b0);
    cmp("mh_full", full, !check_en);
    applyStimulus(1'b1, 4'b0001, 8'h80, 1'b0);
    cmp("mh_slot0", out_data, check_en ? 8'h80 : 8'h77);
    drainAll();
    cmp("mh_err_sticky", err, check_en);
    applyStimulus(1'b0, 4'b0000, 8'h00, 1'b0);
    cmp("mh_err_clear", err, 0);

    // Asynchronous reset in the middle of a drain.
    fillAll(8'h60);
    applyStimulus(1'b1, 4'b0000, 8'h00, 1'b1);
    reset_n = 1'b0;
    #2;
    modelClear();
    checkOutput();
    cmp("rst_valid", out_valid, 0);
    cmp("rst_full", full, 0);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'(1 << i), 8'(8'h70 + i), 1'b1);
    cmp("rst_refill_full", full, 0);
    applyStimulus(1'b1, 4'b1000, 8'h73, 1'b1);
    cmp("rst_refill_done", full, 1);
    drainAll();

    // Enable low discards a partial fill.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'(1 << i), 8'(8'h90 + i), 1'b1);
    applyStimulus(1'b0, 4'b0000, 8'h00, 1'b1);
    applyStimulus(1'b1, 4'b1000, 8'h93, 1'b1);
    cmp("en_partial_full", full, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'(1 << i), 8'(8'hB0 + i), 1'b1);
    cmp("en_refill_full", full, 1);
    drainAll();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [3:0] s;
      r = $urandom_range(0, 9);
      if (r < 2)      s = 4'b0000;
      else if (r < 8) s = 4'(1 << $urandom_range(0, 3));
      else            s = 4'($urandom_range(0, 15));
      applyStimulus($urandom_range(0, 19) != 0, s, 8'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
